// File: rtl/id_ex_pipeline_register.sv
// rtl/id_ex_pipeline_register.sv - ID/EX boundary register with stall, flush and valid tracking
// Every output is a flop; controls are gated by Valid_ID so bubbles never write, load or branch.
module id_ex_pipeline_register #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 4
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Stall,
  input  logic                  Flush,
  input  logic                  Valid_ID,
  input  logic                  RegWrite_ID,
  input  logic                  RegDst_ID,
  input  logic                  ALUSrc_ID,
  input  logic                  Branch_ID,
  input  logic                  MemWrite_ID,
  input  logic                  MemRead_ID,
  input  logic                  MemToReg_ID,
  input  logic [ALUOP_W-1:0]    ALUOp_ID,
  input  logic [DATA_W-1:0]     PCPlus4_ID,
  input  logic [DATA_W-1:0]     ReadData1_ID,
  input  logic [DATA_W-1:0]     ReadData2_ID,
  input  logic [DATA_W-1:0]     Imm_ID,
  input  logic [REG_ADDR_W-1:0] Rs_ID,
  input  logic [REG_ADDR_W-1:0] Rt_ID,
  input  logic [REG_ADDR_W-1:0] Rd_ID,
  output logic                  Valid_EX,
  output logic                  RegWrite_EX,
  output logic                  RegDst_EX,
  output logic                  ALUSrc_EX,
  output logic                  Branch_EX,
  output logic                  MemWrite_EX,
  output logic                  MemRead_EX,
  output logic                  MemToReg_EX,
  output logic [ALUOP_W-1:0]    ALUOp_EX,
  output logic [DATA_W-1:0]     PCPlus4_EX,
  output logic [DATA_W-1:0]     ReadData1_EX,
  output logic [DATA_W-1:0]     ReadData2_EX,
  output logic [DATA_W-1:0]     Imm_EX,
  output logic [REG_ADDR_W-1:0] Rs_EX,
  output logic [REG_ADDR_W-1:0] Rt_EX,
  output logic [REG_ADDR_W-1:0] Rd_EX
);

  logic                  r_valid;
  logic                  r_regwrite;
  logic                  r_regdst;
  logic                  r_alusrc;
  logic                  r_branch;
  logic                  r_memwrite;
  logic                  r_memread;
  logic                  r_memtoreg;
  logic [ALUOP_W-1:0]    r_aluop;
  logic [DATA_W-1:0]     r_pcplus4;
  logic [DATA_W-1:0]     r_rd1;
  logic [DATA_W-1:0]     r_rd2;
  logic [DATA_W-1:0]     r_imm;
  logic [REG_ADDR_W-1:0] r_rs;
  logic [REG_ADDR_W-1:0] r_rt;
  logic [REG_ADDR_W-1:0] r_rd;

  logic w_clear;
  logic w_load;

  assign w_clear = Rst | Flush;
  assign w_load  = ~Stall;

  always_ff @(posedge Clk) begin
    if (w_clear) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_regdst   <= 1'b0;
      r_alusrc   <= 1'b0;
      r_branch   <= 1'b0;
      r_memwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memtoreg <= 1'b0;
      r_aluop    <= '0;
      r_pcplus4  <= '0;
      r_rd1      <= '0;
      r_rd2      <= '0;
      r_imm      <= '0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_rd       <= '0;
    end else if (w_load) begin
      // AND-gating keeps controls at 0 even when unknown control inputs arrive with Valid_ID=0
      r_valid    <= Valid_ID;
      r_regwrite <= Valid_ID & RegWrite_ID;
      r_regdst   <= Valid_ID & RegDst_ID;
      r_alusrc   <= Valid_ID & ALUSrc_ID;
      r_branch   <= Valid_ID & Branch_ID;
      r_memwrite <= Valid_ID & MemWrite_ID;
      r_memread  <= Valid_ID & MemRead_ID;
      r_memtoreg <= Valid_ID & MemToReg_ID;
      r_aluop    <= {ALUOP_W{Valid_ID}} & ALUOp_ID;
      r_pcplus4  <= PCPlus4_ID;
      r_rd1      <= ReadData1_ID;
      r_rd2      <= ReadData2_ID;
      r_imm      <= Imm_ID;
      r_rs       <= Rs_ID;
      r_rt       <= Rt_ID;
      r_rd       <= Rd_ID;
    end
  end

  assign Valid_EX     = r_valid;
  assign RegWrite_EX  = r_regwrite;
  assign RegDst_EX    = r_regdst;
  assign ALUSrc_EX    = r_alusrc;
  assign Branch_EX    = r_branch;
  assign MemWrite_EX  = r_memwrite;
  assign MemRead_EX   = r_memread;
  assign MemToReg_EX  = r_memtoreg;
  assign ALUOp_EX     = r_aluop;
  assign PCPlus4_EX   = r_pcplus4;
  assign ReadData1_EX = r_rd1;
  assign ReadData2_EX = r_rd2;
  assign Imm_EX       = r_imm;
  assign Rs_EX        = r_rs;
  assign Rt_EX        = r_rt;
  assign Rd_EX        = r_rd;

endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// tb/tb_id_ex_pipeline_register.sv - scoreboard bench for id_ex_pipeline_register
module tb_id_ex_pipeline_register;

  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic        regdst;
    logic        alusrc;
    logic        branch;
    logic        memwrite;
    logic        memread;
    logic        memtoreg;
    logic [3:0]  aluop;
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } slot_t;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  logic  stall = 1'b0;
  logic  flush = 1'b0;
  slot_t in_s = '0;
  slot_t out_s;
  slot_t model = '0;
  slot_t exp_q[$];
  int    n_vec = 0;
  int    n_bad = 0;

  always #5 clk = ~clk;

  id_ex_pipeline_register dut (
    .Clk(clk), .Rst(rst), .Stall(stall), .Flush(flush),
    .Valid_ID(in_s.valid), .RegWrite_ID(in_s.regwrite), .RegDst_ID(in_s.regdst),
    .ALUSrc_ID(in_s.alusrc), .Branch_ID(in_s.branch), .MemWrite_ID(in_s.memwrite),
    .MemRead_ID(in_s.memread), .MemToReg_ID(in_s.memtoreg), .ALUOp_ID(in_s.aluop),
    .PCPlus4_ID(in_s.pc), .ReadData1_ID(in_s.rd1), .ReadData2_ID(in_s.rd2),
    .Imm_ID(in_s.imm), .Rs_ID(in_s.rs), .Rt_ID(in_s.rt), .Rd_ID(in_s.rd),
    .Valid_EX(out_s.valid), .RegWrite_EX(out_s.regwrite), .RegDst_EX(out_s.regdst),
    .ALUSrc_EX(out_s.alusrc), .Branch_EX(out_s.branch), .MemWrite_EX(out_s.memwrite),
    .MemRead_EX(out_s.memread), .MemToReg_EX(out_s.memtoreg), .ALUOp_EX(out_s.aluop),
    .PCPlus4_EX(out_s.pc), .ReadData1_EX(out_s.rd1), .ReadData2_EX(out_s.rd2),
    .Imm_EX(out_s.imm), .Rs_EX(out_s.rs), .Rt_EX(out_s.rt), .Rd_EX(out_s.rd)
  );

  // Reference: what the EX slot should hold after an edge with these controls
  function automatic slot_t next_slot(slot_t cur, logic r, logic f, logic s, slot_t id);
    slot_t n;
    if (r || f) return '0;
    if (s) return cur;
    n = id;
    if (id.valid !== 1'b1) begin
      n.valid = 1'b0;
      {n.regwrite, n.regdst, n.alusrc, n.branch, n.memwrite, n.memread, n.memtoreg} = '0;
      n.aluop = 4'd0;
    end
    return n;
  endfunction

  task automatic step(input logic r, input logic f, input logic s, input slot_t id);
    @(negedge clk);
    rst = r; flush = f; stall = s; in_s = id;
    @(posedge clk);
    model = next_slot(model, r, f, s, id);
    exp_q.push_back(model);
  endtask

  function automatic slot_t rand_slot();
    slot_t v;
    v.valid    = ($urandom_range(0, 3) != 0);
    v.regwrite = 1'($urandom);
    v.regdst   = 1'($urandom);
    v.alusrc   = 1'($urandom);
    v.branch   = 1'($urandom);
    v.memwrite = 1'($urandom);
    v.memread  = 1'($urandom);
    v.memtoreg = 1'($urandom);
    v.aluop    = 4'($urandom);
    v.pc       = $urandom;
    v.rd1      = $urandom;
    v.rd2      = $urandom;
    v.imm      = $urandom;
    v.rs       = 5'($urandom);
    v.rt       = 5'($urandom);
    v.rd       = 5'($urandom);
    return v;
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      slot_t e;
      e = exp_q.pop_front();
      n_vec++;
      if (out_s !== e) begin
        n_bad++;
        $display("FAIL slot_compare t=%0t: got %h expected %h", $time, out_s, e);
      end
      n_vec++;
      if (out_s.valid !== 1'b1 &&
          (out_s.regwrite | out_s.memwrite | out_s.memread | out_s.branch) !== 1'b0) begin
        n_bad++;
        $display("FAIL bubble_invariant t=%0t: got rw=%b mw=%b mr=%b br=%b expected all 0",
                 $time, out_s.regwrite, out_s.memwrite, out_s.memread, out_s.branch);
      end
    end
  end

  initial begin
    slot_t a, b, x;
    int    wait_cyc;

    // Reset with every input high
    step(1'b1, 1'b1, 1'b1, '1);
    step(1'b1, 1'b1, 1'b1, '1);

    // R-type then back-to-back addi
    a = '0; a.valid = 1; a.regwrite = 1; a.regdst = 1; a.memtoreg = 1; a.aluop = 4'b0000;
    a.rd1 = 32'h5; a.rd2 = 32'h3; a.rd = 5'd9; a.pc = 32'h0000_0104; a.rs = 5'd1; a.rt = 5'd2;
    step(1'b0, 1'b0, 1'b0, a);
    b = '0; b.valid = 1; b.regwrite = 1; b.alusrc = 1; b.aluop = 4'b0001;
    b.imm = 32'hFFFF_FFFC; b.rs = 5'd4; b.rt = 5'd7; b.rd1 = 32'h40; b.pc = 32'h0000_0108;
    step(1'b0, 1'b0, 1'b0, b);

    // Stall three cycles while ID changes, then release
    step(1'b0, 1'b0, 1'b0, a);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, b);
    step(1'b0, 1'b0, 1'b0, b);

    // Flush together with stall, then resume
    a.memwrite = 1;
    step(1'b0, 1'b0, 1'b0, a);
    step(1'b0, 1'b1, 1'b1, b);
    step(1'b0, 1'b0, 1'b0, b);

    // Invalid decode slot with live-looking controls
    x = b; x.valid = 0; x.regwrite = 1; x.memwrite = 1; x.aluop = 4'b0110;
    step(1'b0, 1'b0, 1'b0, x);

    // Reset during stall, then stall continues
    step(1'b0, 1'b0, 1'b0, a);
    step(1'b0, 1'b0, 1'b1, b);
    step(1'b1, 1'b0, 1'b1, b);
    step(1'b0, 1'b0, 1'b1, b);
    step(1'b0, 1'b0, 1'b1, a);

    // Unknown control inputs with Valid_ID low
    x = a; x.valid = 0;
    x.regwrite = 1'bx; x.memwrite = 1'bx; x.memread = 1'bx; x.branch = 1'bx; x.aluop = 4'bxxxx;
    step(1'b0, 1'b0, 1'b0, x);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) == 0), rand_slot());
    end

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (exp_q.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
